trap_controller: RTL and testbench
==================================

// Module: trap_controller
// PURPOSE
// Machine-mode trap sequencer, directly downstream of the CSR file. Consumes timeint plus the software and
// external interrupt lines, together with the current MSTATUS, MIE, MTVEC and MEPC values. Arbitrates synchronous
// exceptions, pending interrupts and MRET, then drives the CSR trap-write (conflict) ports. It also issues a
// single-cycle PC redirect to the fetch stage.
// PARAMETERS
// XLEN        32   datapath / CSR width
// SYNC_STAGES 2    flops on asynchronous extint_in (>=2)
// PORTS
// clk             in   1     clock
// rst_n           in   1     reset: synchronous, active-low
// timeint_in      in   1     machine timer interrupt, synchronous to clk
// swint_in        in   1     machine software interrupt, synchronous to clk
// extint_in       in   1     machine external interrupt, asynchronous
// mstatus_in      in   XLEN  current MSTATUS
// mie_in          in   XLEN  current MIE
// mtvec_in        in   XLEN  current MTVEC
// mepc_in         in   XLEN  current MEPC
// exc_valid       in   1     synchronous exception, single-cycle pulse
// exc_cause       in   4     exception code
// exc_pc          in   XLEN  PC of faulting instruction
// exc_tval        in   XLEN  trap value
// mret            in   1     MRET retiring, single-cycle pulse
// boundary        in   1     instruction boundary; interrupt may be taken here
// next_pc         in   XLEN  PC of the next instruction, valid when boundary=1
// debug           in   1     debug mode; masks interrupts only
// mip_out         out  XLEN  registered MIP: bit11 MEIP, bit7 MTIP, bit3 MSIP, all other bits 0
// trap_busy       out  1     high while in WRITE or REDIRECT
// mstatus_wr_en / mstatus_wr_data   out 1/XLEN  MSTATUS write strobe / data
// mcause_wr_en  / mcause_wr_data    out 1/XLEN  MCAUSE write strobe / data
// mepc_wr_en    / mepc_wr_data      out 1/XLEN  MEPC write strobe / data
// mtval_wr_en   / mtval_wr_data     out 1/XLEN  MTVAL write strobe / data
// redirect_valid / redirect_pc      out 1/XLEN  fetch redirect, single-cycle
// BEHAVIOUR
// - Reset: state IDLE; all *_wr_en, redirect_valid and trap_busy = 0; all data outputs = 0; mip_out = 0;
//   synchronizer flops = 0. Reset asserted mid-sequence aborts the sequence with no further writes or redirect.
// - extint_in passes through a SYNC_STAGES-flop synchronizer. mip_out is registered every cycle from the
//   synchronized external line, timeint_in and swint_in, giving one cycle of latency after synchronization.
// - pending = mip_out & mie_in & {XLEN{mstatus_in[3]}}, forced to 0 when debug=1.
//   Interrupt priority: MEI (code 11) > MSI (3) > MTI (7).
// - IDLE. Events are checked in priority order:
//   1. exc_valid: latch cause = {0, exc_cause}, epc = exc_pc, tval = exc_tval. Go to WRITE.
//      Taken regardless of MIE or debug.
//   2. Else mret: latch the mret flag. Go to WRITE.
//   3. Else boundary && |pending: latch cause = {1, code}, epc = next_pc, tval = 0. Go to WRITE.
// - WRITE (one cycle).
//   - Trap: assert all four wr_en. mstatus_wr_data = mstatus_in with MPIE <= MIE, MIE <= 0, MPP[12:11] <= 2'b11.
//   - MRET: assert only mstatus_wr_en. mstatus_wr_data = mstatus_in with MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
//   - Go to REDIRECT.
// - REDIRECT (one cycle). redirect_valid = 1. Return to IDLE.
//   - MRET: redirect_pc = mepc_in.
//   - Trap: redirect_pc = {mtvec_in[XLEN-1:2], 2'b00}.
// - Latency: event sampled at edge N; wr_en high in cycle N+1; redirect_valid high in cycle N+2.
// - exc_valid, mret and boundary are ignored while trap_busy=1. The core stalls during this time; the bench asserts
//   that no exc_valid or mret arrives while busy.
// - A simultaneous exception and interrupt takes the exception. The interrupt remains pending for a later boundary.
// - MTVEC mode values 2 and 3 are reserved and are treated as direct mode. Vector address arithmetic wraps
//   modulo 2^XLEN.
// CONFIGURATION
// TRAP_CONTROLLER_VECTORED_EN: when defined and mtvec_in[1:0] == 2'b01, an interrupt trap redirects to
//   base + 4*code; exceptions still go to base. When undefined, mtvec_in[1:0] is ignored and all traps go to base.
// TESTING
// 1. Reset held 3 cycles -> every output 0; mip_out = 0 even with all interrupt inputs high.
// 2. mstatus=0x8, mie=0x80, mtvec=0x100, timeint=1, boundary=1, next_pc=0x2000
//    -> WRITE: mcause=0x80000007, mepc=0x2000, mtval=0, mstatus=0x1880; next cycle redirect_pc=0x100.
// 3. VECTORED_EN defined, mtvec=0x101, mie=0x800, MIE=1, extint_in raised
//    -> MEIP appears after sync + 1 cycle; mcause=0x8000000B; redirect_pc=0x12C.
//    Repeat with the macro undefined -> redirect_pc=0x100.
// 4. mstatus=0, exc_valid, exc_cause=2, exc_pc=0x40, exc_tval=0xDEAD
//    -> mcause=2, mepc=0x40, mtval=0xDEAD, mstatus=0x1800, redirect to base even with vectored mtvec.
// 5. exc_valid coincident with boundary and a pending MTI -> exception taken first;
//    the MTI is taken at the next boundary after return to IDLE; debug=1 blocks that MTI.
// 6. mret with mstatus=0x1880, mepc=0x2000 -> only mstatus_wr_en asserted, data=0x1888; redirect_pc=0x2000.
//    Reset pulsed during WRITE -> no redirect follows.

Source files
------------

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap sequencer sitting after the CSR file.
// Picks one event per idle cycle (exception > MRET > interrupt at a boundary),
// spends one cycle driving the CSR trap-write ports, then one cycle driving
// a PC redirect to fetch.
//
// Build option: define TRAP_CONTROLLER_VECTORED_EN to honour MTVEC vectored
// mode (mode 01) for interrupts. Without it every trap goes to the MTVEC base.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for exception, MRET or interrupt at a boundary
// WRITE    | drive CSR write strobes/data for the latched event
// REDIRECT | pulse redirect_valid with the handler or return address
module trap_controller #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            timeint_in,
  input  logic            swint_in,
  input  logic            extint_in,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mie_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            boundary,
  input  logic [XLEN-1:0] next_pc,
  input  logic            debug,
  output logic [XLEN-1:0] mip_out,
  output logic            trap_busy,
  output logic            mstatus_wr_en,
  output logic [XLEN-1:0] mstatus_wr_data,
  output logic            mcause_wr_en,
  output logic [XLEN-1:0] mcause_wr_data,
  output logic            mepc_wr_en,
  output logic [XLEN-1:0] mepc_wr_data,
  output logic            mtval_wr_en,
  output logic [XLEN-1:0] mtval_wr_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] ext_sync;
  logic [XLEN-1:0]        mip_next;
  logic [XLEN-1:0]        pending;
  logic                   int_req;
  logic [3:0]             int_code;

  logic                   take_exc;
  logic                   take_mret;
  logic                   take_int;

  logic                   lat_mret;
  logic [XLEN-1:0]        lat_cause;
  logic [XLEN-1:0]        lat_epc;
  logic [XLEN-1:0]        lat_tval;

  logic [XLEN-1:0]        trap_status;
  logic [XLEN-1:0]        mret_status;
  logic [XLEN-1:0]        mtvec_base;
  logic [XLEN-1:0]        trap_target;

  // Resynchronise the asynchronous external interrupt line.
  always_ff @(posedge clk) begin
    if (!rst_n) ext_sync <= '0;
    else        ext_sync <= {ext_sync[SYNC_STAGES-2:0], extint_in};
  end

  // Assemble the next MIP image from the three interrupt sources.
  always_comb begin
    mip_next           = '0;
    mip_next[MIP_MEIP] = ext_sync[SYNC_STAGES-1];
    mip_next[MIP_MTIP] = timeint_in;
    mip_next[MIP_MSIP] = swint_in;
  end

  // Register MIP every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) mip_out <= '0;
    else        mip_out <= mip_next;
  end

  // Enabled, globally unmasked interrupts; debug mode hides them all.
  always_comb begin
    pending = mip_out & mie_in & {XLEN{mstatus_in[MSTATUS_MIE]}};
    if (debug) pending = '0;
  end

  // Interrupt priority: external, then software, then timer.
  always_comb begin
    int_req  = 1'b0;
    int_code = 4'd0;
    if (pending[MIP_MEIP]) begin
      int_req  = 1'b1;
      int_code = 4'd11;
    end else if (pending[MIP_MSIP]) begin
      int_req  = 1'b1;
      int_code = 4'd3;
    end else if (pending[MIP_MTIP]) begin
      int_req  = 1'b1;
      int_code = 4'd7;
    end
  end

  // Event selection in IDLE; everything else is ignored while busy.
  always_comb begin
    take_exc  = 1'b0;
    take_mret = 1'b0;
    take_int  = 1'b0;
    if (state == IDLE) begin
      if (exc_valid)                take_exc  = 1'b1;
      else if (mret)                take_mret = 1'b1;
      else if (boundary && int_req) take_int  = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Capture the accepted event; held until the next acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_mret  <= 1'b0;
      lat_cause <= '0;
      lat_epc   <= '0;
      lat_tval  <= '0;
    end else if (take_exc) begin
      lat_mret  <= 1'b0;
      lat_cause <= {{(XLEN-4){1'b0}}, exc_cause};
      lat_epc   <= exc_pc;
      lat_tval  <= exc_tval;
    end else if (take_mret) begin
      lat_mret  <= 1'b1;
    end else if (take_int) begin
      lat_mret  <= 1'b0;
      lat_cause <= {1'b1, {(XLEN-5){1'b0}}, int_code};
      lat_epc   <= next_pc;
      lat_tval  <= '0;
    end
  end

  // MSTATUS images for trap entry and for MRET.
  always_comb begin
    trap_status               = mstatus_in;
    trap_status[MSTATUS_MPIE] = mstatus_in[MSTATUS_MIE];
    trap_status[MSTATUS_MIE]  = 1'b0;
    trap_status[12:11]        = 2'b11;
    mret_status               = mstatus_in;
    mret_status[MSTATUS_MIE]  = mstatus_in[MSTATUS_MPIE];
    mret_status[MSTATUS_MPIE] = 1'b1;
    mret_status[12:11]        = 2'b11;
  end

  assign mtvec_base = {mtvec_in[XLEN-1:2], 2'b00};

`ifdef TRAP_CONTROLLER_VECTORED_EN
  // Vectored mode only for interrupts; reserved modes 2/3 act as direct.
  always_comb begin
    trap_target = mtvec_base;
    if (lat_cause[XLEN-1] && (mtvec_in[1:0] == 2'b01))
      trap_target = mtvec_base + XLEN'({lat_cause[3:0], 2'b00});
  end
`else
  // Direct mode only: the MTVEC mode field is a don't-care here.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_in[1:0];

  // Every trap goes to the base address.
  always_comb begin
    trap_target = mtvec_base;
  end
`endif

  // Next state and CSR/redirect outputs, all zero outside their cycle.
  always_comb begin
    state_next      = state;
    trap_busy       = 1'b0;
    mstatus_wr_en   = 1'b0;
    mstatus_wr_data = '0;
    mcause_wr_en    = 1'b0;
    mcause_wr_data  = '0;
    mepc_wr_en      = 1'b0;
    mepc_wr_data    = '0;
    mtval_wr_en     = 1'b0;
    mtval_wr_data   = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    case (state)
      IDLE: begin
        if (take_exc || take_mret || take_int) state_next = WRITE;
      end
      WRITE: begin
        trap_busy     = 1'b1;
        mstatus_wr_en = 1'b1;
        if (lat_mret) begin
          mstatus_wr_data = mret_status;
        end else begin
          mstatus_wr_data = trap_status;
          mcause_wr_en    = 1'b1;
          mcause_wr_data  = lat_cause;
          mepc_wr_en      = 1'b1;
          mepc_wr_data    = lat_epc;
          mtval_wr_en     = 1'b1;
          mtval_wr_data   = lat_tval;
        end
        state_next = REDIRECT;
      end
      REDIRECT: begin
        trap_busy      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = lat_mret ? mepc_in : trap_target;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller. Stimulus pushes expected CSR-write and
// redirect records into a queue; a negedge monitor pops one whenever the DUT
// shows a write strobe or a redirect and compares it.
module tb_trap_controller;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            timeint_in, swint_in, extint_in;
  logic [XLEN-1:0] mstatus_in, mie_in, mtvec_in, mepc_in;
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_pc, exc_tval;
  logic            mret, boundary, debug;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] mip_out;
  logic            trap_busy;
  logic            mstatus_wr_en, mcause_wr_en, mepc_wr_en, mtval_wr_en;
  logic [XLEN-1:0] mstatus_wr_data, mcause_wr_data, mepc_wr_data, mtval_wr_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  always #5 clk = ~clk;

  trap_controller #(.XLEN(XLEN), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .timeint_in(timeint_in), .swint_in(swint_in), .extint_in(extint_in),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret(mret), .boundary(boundary), .next_pc(next_pc), .debug(debug),
    .mip_out(mip_out), .trap_busy(trap_busy),
    .mstatus_wr_en(mstatus_wr_en), .mstatus_wr_data(mstatus_wr_data),
    .mcause_wr_en(mcause_wr_en), .mcause_wr_data(mcause_wr_data),
    .mepc_wr_en(mepc_wr_en), .mepc_wr_data(mepc_wr_data),
    .mtval_wr_en(mtval_wr_en), .mtval_wr_data(mtval_wr_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // en = {mstatus, mcause, mepc, mtval}
  typedef struct {
    bit          redir;
    logic [3:0]  en;
    logic [31:0] mstatus;
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

`ifdef TRAP_CONTROLLER_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_trap(input logic [31:0] ms, input logic [31:0] cause,
                           input logic [31:0] epc, input logic [31:0] tval,
                           input logic [31:0] pc);
    exp_t e;
    e = '{redir: 1'b0, en: 4'b1111, mstatus: ms, mcause: cause, mepc: epc, mtval: tval, pc: 32'h0};
    sb.push_back(e);
    e = '{redir: 1'b1, en: 4'b0000, mstatus: 32'h0, mcause: 32'h0, mepc: 32'h0, mtval: 32'h0, pc: pc};
    sb.push_back(e);
  endtask

  task automatic push_mret(input logic [31:0] ms, input logic [31:0] pc, input bit with_redirect);
    exp_t e;
    e = '{redir: 1'b0, en: 4'b1000, mstatus: ms, mcause: 32'h0, mepc: 32'h0, mtval: 32'h0, pc: 32'h0};
    sb.push_back(e);
    if (with_redirect) begin
      e = '{redir: 1'b1, en: 4'b0000, mstatus: 32'h0, mcause: 32'h0, mepc: 32'h0, mtval: 32'h0, pc: pc};
      sb.push_back(e);
    end
  endtask

  // Scoreboard monitor and the no-event-while-busy assertion.
  always @(negedge clk) begin
    exp_t e;
    if (trap_busy && (exc_valid || mret)) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_event: exc_valid=%0b mret=%0b arrived while busy", exc_valid, mret);
    end
    if (mstatus_wr_en || mcause_wr_en || mepc_wr_en || mtval_wr_en) begin
      if (sb.size() == 0 || sb[0].redir) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: en=%b expected none", {mstatus_wr_en, mcause_wr_en, mepc_wr_en, mtval_wr_en});
      end else begin
        e = sb.pop_front();
        check("wr_en", {28'h0, mstatus_wr_en, mcause_wr_en, mepc_wr_en, mtval_wr_en}, {28'h0, e.en});
        check("mstatus_wr_data", mstatus_wr_data, e.mstatus);
        check("busy_in_write", {31'h0, trap_busy}, 32'h1);
        if (e.en[2]) begin
          check("mcause_wr_data", mcause_wr_data, e.mcause);
          check("mepc_wr_data", mepc_wr_data, e.mepc);
          check("mtval_wr_data", mtval_wr_data, e.mtval);
        end
      end
    end
    if (redirect_valid) begin
      if (sb.size() == 0 || !sb[0].redir) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_redirect: pc=0x%08h expected none", redirect_pc);
      end else begin
        e = sb.pop_front();
        check("redirect_pc", redirect_pc, e.pc);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    timeint_in = 1'b1; swint_in = 1'b1; extint_in = 1'b1;
    mstatus_in = '0; mie_in = '0; mtvec_in = '0; mepc_in = '0;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret = 1'b0; boundary = 1'b0; next_pc = '0; debug = 1'b0;

    // Reset held with every interrupt line high.
    tick(3);
    check("rst_mip", mip_out, 32'h0);
    check("rst_en", {27'h0, trap_busy, mstatus_wr_en, mcause_wr_en, mepc_wr_en, mtval_wr_en}, 32'h0);
    check("rst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
    check("rst_mstatus_data", mstatus_wr_data, 32'h0);
    check("rst_mcause_data", mcause_wr_data, 32'h0);
    check("rst_mepc_data", mepc_wr_data, 32'h0);
    check("rst_mtval_data", mtval_wr_data, 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    timeint_in = 1'b0; swint_in = 1'b0; extint_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("idle_mip", mip_out, 32'h0);

    // Timer interrupt at a boundary.
    mstatus_in = 32'h8; mie_in = 32'h80; mtvec_in = 32'h100;
    timeint_in = 1'b1;
    tick(1);
    check("mip_mtip", mip_out, 32'h80);
    push_trap(32'h1880, 32'h8000_0007, 32'h2000, 32'h0, 32'h100);
    next_pc = 32'h2000; boundary = 1'b1;
    tick(1);
    boundary = 1'b0;
    tick(3);
    timeint_in = 1'b0;
    tick(2);

    // External interrupt through the synchronizer, vectored MTVEC.
    mie_in = 32'h800; mtvec_in = 32'h101; mstatus_in = 32'h8;
    extint_in = 1'b1;
    tick(2);
    check("mip_meip_sync", mip_out, 32'h0);
    tick(1);
    check("mip_meip", mip_out, 32'h800);
    push_trap(32'h1880, 32'h8000_000B, 32'h2400, 32'h0, VEC ? 32'h12C : 32'h100);
    next_pc = 32'h2400; boundary = 1'b1;
    tick(1);
    boundary = 1'b0;
    tick(3);
    extint_in = 1'b0;
    tick(4);

    // Exception goes to base even with vectored MTVEC.
    mstatus_in = 32'h0;
    push_trap(32'h1800, 32'h2, 32'h40, 32'hDEAD, 32'h100);
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h40; exc_tval = 32'hDEAD;
    tick(1);
    exc_valid = 1'b0;
    tick(3);

    // Exception and pending MTI together: exception first, MTI later.
    mstatus_in = 32'h8; mie_in = 32'h80; timeint_in = 1'b1;
    tick(2);
    push_trap(32'h1880, 32'h5, 32'h80, 32'h11, 32'h100);
    exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h80; exc_tval = 32'h11;
    boundary = 1'b1; next_pc = 32'h3000;
    tick(1);
    exc_valid = 1'b0; boundary = 1'b0;
    tick(3);
    check("idle_after_exc", {31'h0, trap_busy}, 32'h0);
    push_trap(32'h1880, 32'h8000_0007, 32'h3004, 32'h0, VEC ? 32'h11C : 32'h100);
    next_pc = 32'h3004; boundary = 1'b1;
    tick(1);
    boundary = 1'b0;
    tick(3);
    debug = 1'b1; next_pc = 32'h3008; boundary = 1'b1;
    tick(1);
    boundary = 1'b0;
    tick(1);
    check("debug_blocks_int", {31'h0, trap_busy}, 32'h0);
    tick(2);
    debug = 1'b0;

    // Software beats timer when both pending.
    mie_in = 32'h88; swint_in = 1'b1;
    tick(1);
    check("mip_msip_mtip", mip_out, 32'h88);
    push_trap(32'h1880, 32'h8000_0003, 32'h3100, 32'h0, VEC ? 32'h10C : 32'h100);
    next_pc = 32'h3100; boundary = 1'b1;
    tick(1);
    boundary = 1'b0;
    tick(3);
    timeint_in = 1'b0; swint_in = 1'b0;
    tick(2);

    // MRET.
    mstatus_in = 32'h1880; mepc_in = 32'h2000;
    push_mret(32'h1888, 32'h2000, 1'b1);
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
    tick(3);

    // Reset during WRITE: the write is seen, no redirect follows.
    push_mret(32'h1888, 32'h0, 1'b0);
    mret = 1'b1;
    tick(1);
    mret = 1'b0; rst_n = 1'b0;
    tick(1);
    check("abort_busy", {31'h0, trap_busy}, 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(4);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
